cycle_sequencer: RTL
====================

# cycle_sequencer

Opcode-fetch and T-state sequencer for the 65C02 core. It generates the instruction-register load strobe (`ir_signal`) and SYNC on every opcode fetch, and counts execution cycles T1..T7 until the decoder flags the last cycle. It also runs the 7-cycle reset sequence, arbitrates NMI/IRQ by forcing BRK injection at fetch, and parks the core for WAI/STP. It sits between the decoder and the instruction register.

## Interface
- `RST_CYCLES`, 7: number of enabled cycles in the reset sequence (3..7).
- `fclk`  in  1  core clock; sole clock.
- `resb`  in  1  reset; asynchronous assert, active-low.
- `phi2_en`  in  1  cycle enable; one bus cycle advances per `fclk` edge with `phi2_en`=1.
- `rdy`  in  1  high = proceed; low freezes state, T-count and strobes.
- `last_cycle`  in  1  decoder: current EXEC cycle is the final one.
- `is_wai`, `is_stp`  in  1 each  decoder: current instruction is WAI / STP (valid with `last_cycle`).
- `nmib`, `irqb`  in  1 each  active-low interrupt pins, synchronous to `fclk`.
- `i_flag`  in  1  processor I flag.
- `ir_signal`  out  1  IR load strobe.
- `sync`  out  1  opcode-fetch cycle indicator.
- `tstate`  out  3  0 at fetch, 1..7 in execution.
- `force_brk`  out  1  IR mux selects $00 instead of `data_in`.
- `vector_sel`  out  2  00 BRK/none, 01 IRQ, 10 NMI, 11 reset.
- `rst_active`  out  1  reset sequence in progress.
- `seq_error`  out  1  sticky: instruction overran T7.

## Operation
- States: RESET_SEQ, FETCH, EXEC, WAIT, STOP. "Advance" = `phi2_en & rdy`.
- RESET_SEQ: `rst_active`=1, `vector_sel`=11, `tstate` counts 0..`RST_CYCLES`-1 on each advance. After the last count → FETCH.
- FETCH: `sync`=1, `tstate`=0, `ir_signal` = `sync & phi2_en & rdy`. On advance → EXEC with `tstate`=1.
- Interrupt at FETCH, evaluated combinationally:
  - If `nmi_pending`: `force_brk`=1, `vector_sel`=10; `nmi_pending` clears on that advance.
  - Else if `irqb`=0 and `i_flag`=0: `force_brk`=1, `vector_sel`=01.
  - Otherwise `force_brk`=0, `vector_sel`=00.
- EXEC: on advance with `last_cycle`=1:
  - → STOP if `is_stp`.
  - Else → WAIT if `is_wai`.
  - Else → FETCH.
  - `is_stp` has priority over `is_wai`.
- EXEC without `last_cycle`: `tstate` increments. At `tstate`=7 an advance without `last_cycle` forces → FETCH and sets `seq_error`.
- WAIT: `tstate`=0, `sync`=0. Exits to FETCH on the first `phi2_en` edge (`rdy` ignored) with `nmi_pending`=1 or `irqb`=0. The interrupt is then taken at FETCH only per the rules above, so with I=1 execution resumes at the next opcode.
- STOP: all strobes 0; only `resb` exits.
- NMI detect: `nmib` sampled on every `phi2_en` edge, independent of `rdy` and state. A 1→0 transition sets `nmi_pending`. A new edge while pending is absorbed (single pending).

## Timing
- Reset (async, `resb`=0): state=RESET_SEQ, `tstate`=0, `nmi_pending`=0, `seq_error`=0, NMI sampler=1.
- Reset output values: `ir_signal`=0, `sync`=0, `force_brk`=0, `vector_sel`=11, `rst_active`=1.
- Reset mid-instruction aborts immediately; the sequence restarts from count 0 after deassert.
- State and counters update on rising `fclk` only. `sync`, `force_brk`, `vector_sel` and `rst_active` decode from registered state. `ir_signal` additionally gates on `phi2_en & rdy` and is high for exactly one `fclk` per fetch.
- Minimum instruction: FETCH + T1 with `last_cycle` = 2 advances. Maximum: 8 (T0..T7).
- `rdy`=0 holds all outputs constant except `ir_signal`, which is forced 0.
- An NMI edge and FETCH in the same advance: not taken at that fetch; taken at the next.

## Configuration
- `WAI_STP_EN` defined: WAIT and STOP states as above.
- `WAI_STP_EN` undefined: WAIT/STOP not built; `is_wai`/`is_stp` ignored, and EXEC with `last_cycle` always → FETCH.

## Test plan
- Reset sequence: `resb` low, release, `phi2_en`=1 each cycle → `rst_active`=1 for 7 advances, then `sync`=1, `ir_signal` pulses once, `vector_sel`=00.
- 2-cycle and 4-cycle instructions: `last_cycle` at T1 vs T3 → `tstate` 0,1,0 and 0,1,2,3,0; `ir_signal` once per fetch.
- NMI during an IRQ with I=0: `nmib` 1→0 mid-EXEC, `irqb`=0 → next FETCH has `force_brk`=1, `vector_sel`=10. The following FETCH with `irqb` still low gives `vector_sel`=01.
- `rdy`=0 for 3 cycles at FETCH → `ir_signal`=0 throughout and `tstate` frozen; a single strobe occurs once `rdy` returns to 1.
- Overrun: `last_cycle` never asserted → `tstate` reaches 7, next advance returns to FETCH and `seq_error`=1 until `resb`.
- WAI with I=1 (`WAI_STP_EN`): `is_wai`+`last_cycle` → WAIT; `irqb`=0 → FETCH with `force_brk`=0. STP → STOP, ignoring `nmib` edges until reset.

Source files
------------

// File: rtl/cycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// cycle_sequencer_if
// Bundles the decoder / interrupt-pin side of the 65C02 cycle sequencer.
//
//   phi2_en     cycle enable (one bus cycle per fclk edge when high)
//   rdy         high = proceed, low = freeze
//   last_cycle  decoder: current execution cycle is the final one
//   is_wai      decoder: current instruction is WAI (valid with last_cycle)
//   is_stp      decoder: current instruction is STP (valid with last_cycle)
//   nmib        active-low NMI pin, synchronous to fclk
//   irqb        active-low IRQ pin, synchronous to fclk
//   i_flag      processor I flag
//   ir_signal   instruction-register load strobe
//   sync        opcode-fetch cycle indicator
//   tstate      0 at fetch, 1..7 during execution
//   force_brk   IR mux selects $00 instead of the data bus
//   vector_sel  00 BRK/none, 01 IRQ, 10 NMI, 11 reset
//   rst_active  reset sequence in progress
//   seq_error   sticky: an instruction ran past T7
//
// master: the decoder / core side.  slave: the sequencer.
// ---------------------------------------------------------------------------
interface cycle_sequencer_if;
   logic       phi2_en;
   logic       rdy;
   logic       last_cycle;
   logic       is_wai;
   logic       is_stp;
   logic       nmib;
   logic       irqb;
   logic       i_flag;
   logic       ir_signal;
   logic       sync;
   logic [2:0] tstate;
   logic       force_brk;
   logic [1:0] vector_sel;
   logic       rst_active;
   logic       seq_error;

   modport master (
      output phi2_en, rdy, last_cycle, is_wai, is_stp, nmib, irqb, i_flag,
      input  ir_signal, sync, tstate, force_brk, vector_sel, rst_active, seq_error
   );

   modport slave (
      input  phi2_en, rdy, last_cycle, is_wai, is_stp, nmib, irqb, i_flag,
      output ir_signal, sync, tstate, force_brk, vector_sel, rst_active, seq_error
   );
endinterface

// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
// Opcode-fetch and T-state sequencer for the 65C02 core. Runs the reset
// sequence, produces SYNC and the IR load strobe at every opcode fetch,
// counts execution cycles T1..T7, injects BRK for pending NMI/IRQ at fetch
// and parks the core for WAI/STP.
//
// Parameters:
//   RST_CYCLES  enabled cycles in the reset sequence (3..7)
// Ports:
//   fclk        core clock
//   resb        asynchronous active-low reset
//   bus         cycle_sequencer_if.slave (decoder inputs, sequencer outputs)
// Build option:
//   WAI_STP_EN  when defined, builds the WAIT and STOP states; otherwise
//               is_wai / is_stp are ignored.
// ---------------------------------------------------------------------------
module cycle_sequencer #(
   parameter int RST_CYCLES = 7
) (
   input  logic              fclk,
   input  logic              resb,
   cycle_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_RESET_SEQ = 3'd0,
      ST_FETCH     = 3'd1,
      ST_EXEC      = 3'd2,
      ST_WAIT      = 3'd3,
      ST_STOP      = 3'd4
   } state_t;

   localparam logic [2:0] RST_LAST = 3'(RST_CYCLES - 1);
   localparam logic [2:0] T_MAX    = 3'd7;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [2:0] tstate_r;
   logic [2:0] tstate_nxt_s;
   logic       nmi_pending_r;
   logic       nmib_prev_r;
   logic       seq_error_r;
   logic       advance_s;
   logic       nmi_edge_s;
   logic       nmi_take_s;
   logic       err_set_s;
   logic       sync_s;
   logic       force_brk_s;
   logic [1:0] vector_sel_s;
   logic       rst_active_s;

   assign advance_s  = bus.phi2_en & bus.rdy;
   // Falling edge of nmib between two consecutive enabled samples.
   assign nmi_edge_s = nmib_prev_r & ~bus.nmib;

`ifndef WAI_STP_EN
   logic unused_wai_stp_s;
   assign unused_wai_stp_s = bus.is_wai ^ bus.is_stp;
`endif

   // State register, T-state counter, NMI sampler and sticky error flag.
   always_ff @(posedge fclk or negedge resb) begin
      if (!resb) begin
         state_r       <= ST_RESET_SEQ;
         tstate_r      <= 3'd0;
         nmi_pending_r <= 1'b0;
         nmib_prev_r   <= 1'b1;
         seq_error_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         tstate_r <= tstate_nxt_s;
         if (err_set_s) begin
            seq_error_r <= 1'b1;
         end
         // NMI sampling ignores rdy and state; taking the NMI wins over a
         // coincident new edge so only one NMI is ever pending.
         if (bus.phi2_en) begin
            nmib_prev_r <= bus.nmib;
            if (nmi_take_s) begin
               nmi_pending_r <= 1'b0;
            end else if (nmi_edge_s) begin
               nmi_pending_r <= 1'b1;
            end
         end
      end
   end

   // Next-state and next-T-state decode.
   always_comb begin
      state_nxt_s  = state_r;
      tstate_nxt_s = tstate_r;
      err_set_s    = 1'b0;
      nmi_take_s   = 1'b0;
      case (state_r)
         ST_RESET_SEQ: begin
            if (advance_s) begin
               if (tstate_r == RST_LAST) begin
                  state_nxt_s  = ST_FETCH;
                  tstate_nxt_s = 3'd0;
               end else begin
                  tstate_nxt_s = tstate_r + 3'd1;
               end
            end else begin
               state_nxt_s = ST_RESET_SEQ;
            end
         end
         ST_FETCH: begin
            if (advance_s) begin
               state_nxt_s  = ST_EXEC;
               tstate_nxt_s = 3'd1;
               nmi_take_s   = nmi_pending_r;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_EXEC: begin
            if (advance_s) begin
               if (bus.last_cycle) begin
                  tstate_nxt_s = 3'd0;
`ifdef WAI_STP_EN
                  if (bus.is_stp) begin
                     state_nxt_s = ST_STOP;
                  end else if (bus.is_wai) begin
                     state_nxt_s = ST_WAIT;
                  end else begin
                     state_nxt_s = ST_FETCH;
                  end
`else
                  state_nxt_s = ST_FETCH;
`endif
               end else if (tstate_r == T_MAX) begin
                  // Decoder never flagged the last cycle: recover at fetch.
                  state_nxt_s  = ST_FETCH;
                  tstate_nxt_s = 3'd0;
                  err_set_s    = 1'b1;
               end else begin
                  tstate_nxt_s = tstate_r + 3'd1;
               end
            end else begin
               state_nxt_s = ST_EXEC;
            end
         end
`ifdef WAI_STP_EN
         ST_WAIT: begin
            // rdy does not gate the wake-up; the interrupt itself is only
            // taken at fetch if it still qualifies there.
            if (bus.phi2_en && (nmi_pending_r || !bus.irqb)) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_STOP: begin
            state_nxt_s = ST_STOP;
         end
`endif
         default: begin
            state_nxt_s  = ST_RESET_SEQ;
            tstate_nxt_s = 3'd0;
         end
      endcase
   end

   // Output decode from registered state plus fetch-time interrupt arbitration.
   always_comb begin
      sync_s       = 1'b0;
      force_brk_s  = 1'b0;
      vector_sel_s = 2'b00;
      rst_active_s = 1'b0;
      case (state_r)
         ST_RESET_SEQ: begin
            rst_active_s = 1'b1;
            vector_sel_s = 2'b11;
         end
         ST_FETCH: begin
            sync_s = 1'b1;
            if (nmi_pending_r) begin
               force_brk_s  = 1'b1;
               vector_sel_s = 2'b10;
            end else if (!bus.irqb && !bus.i_flag) begin
               force_brk_s  = 1'b1;
               vector_sel_s = 2'b01;
            end else begin
               force_brk_s  = 1'b0;
               vector_sel_s = 2'b00;
            end
         end
         default: begin
            sync_s = 1'b0;
         end
      endcase
   end

   assign bus.sync       = sync_s;
   assign bus.ir_signal  = sync_s & advance_s;
   assign bus.tstate     = tstate_r;
   assign bus.force_brk  = force_brk_s;
   assign bus.vector_sel = vector_sel_s;
   assign bus.rst_active = rst_active_s;
   assign bus.seq_error  = seq_error_r;

endmodule
